// File: rtl/echo_seq_pkg.sv
// echo_seq_pkg: shared FSM encoding, stage indices and default stage masks for echo_seq_ctrl.
package echo_seq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_FIRE, S_WAIT, S_DONE} state_e;
   localparam int ST_CONV   = 0;
   localparam int ST_LAG    = 1;
   localparam int ST_ADAPT  = 2;
   localparam int ST_CANCEL = 3;
   localparam logic [3:0] ADAPT_MASK_DEF  = 4'((1 << ST_CONV) | (1 << ST_LAG) | (1 << ST_ADAPT));
   localparam logic [3:0] CANCEL_MASK_DEF = 4'((1 << ST_CONV) | (1 << ST_LAG) | (1 << ST_CANCEL));
endpackage

// File: rtl/sample_timer.sv
// sample_timer: free-running sample-period counter with a tick while the count is zero.
module sample_timer #(
   parameter int SAMPLE_CYCLE = 4000,
   parameter int CNT_W = 13
) (
   input  logic             clk_operation,
   input  logic             rst,
   output logic [CNT_W-1:0] sampling_cycle_counter,
   output logic             sample_tick
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign cnt_d = (cnt_q == CNT_W'(SAMPLE_CYCLE - 1)) ? '0 : cnt_q + CNT_W'(1);
   always_ff @(posedge clk_operation or negedge rst)
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign sampling_cycle_counter = cnt_q;
   assign sample_tick = cnt_q == '0;
endmodule

// File: rtl/echo_seq_ctrl.sv
// echo_seq_ctrl: per-sample sequencer firing enable pulses to the echo-cancellation stages.
// Optional ECHO_SEQ_STATS_EN adds last_latency/max_latency tick-to-done statistics.
module echo_seq_ctrl import echo_seq_pkg::*; #(
   parameter int SAMPLE_CYCLE = 4000,
   parameter int CNT_W = 13,
   parameter int N_STAGES = 4,
   parameter int PULSE_W = 4,
   parameter int TIMEOUT = 2048,
   parameter logic [N_STAGES-1:0] ADAPT_MASK = N_STAGES'(ADAPT_MASK_DEF),
   parameter logic [N_STAGES-1:0] CANCEL_MASK = N_STAGES'(CANCEL_MASK_DEF)
) (
   input  logic                clk_operation,
   input  logic                rst,
   input  logic                run_en,
   input  logic                mode,
   input  logic [N_STAGES-1:0] stage_ready,
   input  logic                clr_err,
   output logic [N_STAGES-1:0] stage_enable,
   output logic [CNT_W-1:0]    sampling_cycle_counter,
   output logic                sample_tick,
   output logic                out_valid,
   output logic                out_sel,
   output logic                busy,
   output logic [N_STAGES-1:0] timeout_err,
   output logic                overrun
`ifdef ECHO_SEQ_STATS_EN
   ,
   output logic [15:0]         last_latency,
   output logic [15:0]         max_latency
`endif
);
   localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
   localparam int PW_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [N_STAGES-1:0] mask_q, mask_d, rdy_prev_q, terr_q, terr_d, err_set;
   logic [PW_W-1:0]     pcnt_q, pcnt_d;
   logic [TO_W-1:0]     tcnt_q, tcnt_d;
   logic                mode_q, mode_d, edge_q, edge_d, ovr_q, ovr_d;
   logic                tick_go, rise, last;

   sample_timer #(.SAMPLE_CYCLE(SAMPLE_CYCLE), .CNT_W(CNT_W)) u_timer (
      .clk_operation(clk_operation),
      .rst(rst),
      .sampling_cycle_counter(sampling_cycle_counter),
      .sample_tick(sample_tick)
   );

   assign tick_go = sample_tick & run_en;
   // only a fresh 0->1 transition of the addressed stage counts as ready
   assign rise = stage_ready[idx_q] & ~rdy_prev_q[idx_q];
   assign last = idx_q == IDX_W'(N_STAGES - 1);

   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      mask_d = mask_q;
      mode_d = mode_q;
      pcnt_d = pcnt_q;
      tcnt_d = tcnt_q;
      edge_d = edge_q;
      err_set = '0;
      case (state_q)
         S_IDLE: if (tick_go) begin
            mode_d = mode;
            mask_d = mode ? ADAPT_MASK : CANCEL_MASK;
            idx_d = IDX_W'(ST_CONV);
            state_d = S_SELECT;
         end
         S_SELECT: if (mask_q[idx_q]) begin
            state_d = S_FIRE;
            pcnt_d = '0;
            tcnt_d = '0;
            edge_d = 1'b0;
         end else if (last) state_d = S_DONE;
         else idx_d = idx_q + IDX_W'(1);
         S_FIRE: begin
            tcnt_d = tcnt_q + TO_W'(1);
            pcnt_d = pcnt_q + PW_W'(1);
            edge_d = edge_q | rise;
            state_d = (pcnt_q == PW_W'(PULSE_W - 1)) ? S_WAIT : S_FIRE;
         end
         S_WAIT: begin
            tcnt_d = tcnt_q + TO_W'(1);
            if (edge_q | rise) begin
               state_d = last ? S_DONE : S_SELECT;
               idx_d = last ? idx_q : idx_q + IDX_W'(1);
            end else if (tcnt_q >= TO_W'(TIMEOUT - 1)) begin
               err_set[idx_q] = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      terr_d = (clr_err ? '0 : terr_q) | err_set;
      ovr_d = (clr_err ? 1'b0 : ovr_q) | (tick_go & (state_q != S_IDLE));
   end

   always_ff @(posedge clk_operation or negedge rst)
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q <= '0;
         mask_q <= '0;
         mode_q <= 1'b0;
         pcnt_q <= '0;
         tcnt_q <= '0;
         edge_q <= 1'b0;
         rdy_prev_q <= '0;
         terr_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         mask_q <= mask_d;
         mode_q <= mode_d;
         pcnt_q <= pcnt_d;
         tcnt_q <= tcnt_d;
         edge_q <= edge_d;
         rdy_prev_q <= stage_ready;
         terr_q <= terr_d;
         ovr_q <= ovr_d;
      end

   assign busy = state_q != S_IDLE;
   assign out_valid = state_q == S_DONE;
   assign out_sel = out_valid & mode_q;
   assign stage_enable = (state_q == S_FIRE) ? N_STAGES'(1) << idx_q : '0;
   assign timeout_err = terr_q;
   assign overrun = ovr_q;

`ifdef ECHO_SEQ_STATS_EN
   logic [15:0] lat_q, lat_d, last_q, last_d, max_q, max_d, max_base;
   always_comb begin
      lat_d = (state_q == S_IDLE) ? 16'd1 : (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
      last_d = (state_q == S_DONE) ? lat_q : last_q;
      max_base = clr_err ? 16'd0 : max_q;
      max_d = (state_q == S_DONE && lat_q > max_base) ? lat_q : max_base;
   end
   always_ff @(posedge clk_operation or negedge rst)
      if (!rst) begin
         lat_q <= '0;
         last_q <= '0;
         max_q <= '0;
      end else begin
         lat_q <= lat_d;
         last_q <= last_d;
         max_q <= max_d;
      end
   assign last_latency = last_q;
   assign max_latency = max_q;
`endif
endmodule

// File: tb/tb_echo_seq_ctrl.sv
// tb_echo_seq_ctrl: directed vectors for echo_seq_ctrl with stub stages answering 3 clocks after enable.
module tb_echo_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic run_en_a = 1'b0, mode_a = 1'b0, clr_a = 1'b0, hold_a = 1'b0;
   logic run_en_b = 1'b0, mode_b = 1'b0, clr_b = 1'b0;
   logic [3:0] a_rdy, a_en, a_terr, b_rdy, b_en, b_terr;
   logic [5:0] a_cnt;
   logic [3:0] b_cnt;
   logic a_tick, a_ov, a_sel, a_busy, a_ovr;
   logic b_tick, b_ov, b_sel, b_busy, b_ovr;
   logic [3:0] ens [2];
   logic [3:0] en_prev [2] = '{4'h0, 4'h0};
   logic [3:0] stub [2] = '{4'h0, 4'h0};
   logic [3:0] respond [2] = '{4'hF, 4'hF};
   int cnt [2][4];
   int n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   echo_seq_ctrl #(.SAMPLE_CYCLE(64), .CNT_W(6), .TIMEOUT(16)) u_dut_a (
      .clk_operation(clk), .rst(rst), .run_en(run_en_a), .mode(mode_a),
      .stage_ready(a_rdy), .clr_err(clr_a), .stage_enable(a_en),
      .sampling_cycle_counter(a_cnt), .sample_tick(a_tick), .out_valid(a_ov),
      .out_sel(a_sel), .busy(a_busy), .timeout_err(a_terr), .overrun(a_ovr)
   );

   echo_seq_ctrl #(.SAMPLE_CYCLE(16), .CNT_W(4)) u_dut_b (
      .clk_operation(clk), .rst(rst), .run_en(run_en_b), .mode(mode_b),
      .stage_ready(b_rdy), .clr_err(clr_b), .stage_enable(b_en),
      .sampling_cycle_counter(b_cnt), .sample_tick(b_tick), .out_valid(b_ov),
      .out_sel(b_sel), .busy(b_busy), .timeout_err(b_terr), .overrun(b_ovr)
   );

   assign ens[0] = a_en;
   assign ens[1] = b_en;
   assign a_rdy = stub[0] | {3'b000, hold_a};
   assign b_rdy = stub[1];

   // stub stages: ready high from the 4th to the 8th negedge after enable rise
   always @(negedge clk)
      for (int i = 0; i < 2; i++)
         for (int s = 0; s < 4; s++) begin
            cnt[i][s] = (ens[i][s] && !en_prev[i][s]) ? 1 :
                        (cnt[i][s] == 0 || cnt[i][s] >= 15) ? 0 : cnt[i][s] + 1;
            stub[i][s] = respond[i][s] && cnt[i][s] >= 4 && cnt[i][s] <= 8;
            en_prev[i][s] = ens[i][s];
         end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_en(input int k, input int s0, input int s1, input int s2, input int s3);
      int st [4];
      st = '{s0, s1, s2, s3};
      exp_en = '0;
      for (int s = 0; s < 4; s++)
         if (st[s] != 0 && k >= st[s] && k < st[s] + 4) exp_en[s] = 1'b1;
   endfunction

   task automatic wait_tick(input bit b);
      int n = 0;
      while (!(b ? b_tick : a_tick) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("tick_seen", n < 200, 1);
   endtask

   task automatic run_a(input string name, input int len, input int s0, input int s1, input int s2,
                        input int s3, input int done_k, input int busy_end, input logic sel, input bit stale);
      for (int k = 0; k <= len; k++) begin
         chk({name, "_en"}, a_en, exp_en(k, s0, s1, s2, s3));
         chk({name, "_valid"}, a_ov, k == done_k);
         chk({name, "_busy"}, a_busy, k >= 1 && k <= busy_end);
         if (k == done_k) chk({name, "_sel"}, a_sel, sel);
         if (stale) hold_a = (k < 10) || (k >= 13 && k < 16);
         @(negedge clk);
      end
   endtask

   initial begin
      int n_ov;
      repeat (2) @(negedge clk);
      chk("rst_en", a_en, 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_tick", a_tick, 1);
      chk("rst_valid", a_ov, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_terr", a_terr, 0);
      chk("rst_ovr", b_ovr, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("cnt_run", a_cnt, 3);
      mode_a = 1'b1;
      run_en_a = 1'b1;
      wait_tick(0);
      run_a("adapt", 21, 2, 8, 14, 0, 20, 20, 1'b1, 1'b0);
      mode_a = 1'b0;
      wait_tick(0);
      run_a("cancel", 21, 2, 8, 0, 15, 20, 20, 1'b0, 1'b0);
      mode_a = 1'b1;
      respond[0][1] = 1'b0;
      wait_tick(0);
      run_a("timeout", 23, 2, 8, 0, 0, -1, 23, 1'b0, 1'b0);
      chk("timeout_err", a_terr, 4'b0010);
      chk("timeout_idle", a_busy, 0);
      respond[0][1] = 1'b1;
      wait_tick(0);
      run_a("rerun", 21, 2, 8, 14, 0, 20, 20, 1'b1, 1'b0);
      chk("terr_sticky", a_terr, 4'b0010);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      chk("terr_clr", a_terr, 0);
      hold_a = 1'b1;
      wait_tick(0);
      run_a("stale", 28, 2, 15, 21, 0, 27, 27, 1'b1, 1'b1);
      chk("stale_terr", a_terr, 0);
      mode_b = 1'b1;
      run_en_b = 1'b1;
      @(negedge clk);
      wait_tick(1);
      for (int k = 0; k <= 21; k++) begin
         chk("ovr_flag", b_ovr, k >= 17);
         chk("ovr_valid", b_ov, k == 20);
         chk("ovr_busy", b_busy, k >= 1 && k <= 20);
         if (k == 16) chk("ovr_tick", b_tick, 1);
         if (k == 17) run_en_b = 1'b0;
         @(negedge clk);
      end
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      chk("ovr_clr", b_ovr, 0);
      mode_a = 1'b1;
      wait_tick(0);
      repeat (3) @(negedge clk);
      chk("pre_rst_en", a_en, 4'b0001);
      rst = 1'b0;
      run_en_a = 1'b0;
      #1;
      chk("mid_rst_en", a_en, 0);
      chk("mid_rst_cnt", a_cnt, 0);
      chk("mid_rst_busy", a_busy, 0);
      chk("mid_rst_valid", a_ov, 0);
      @(negedge clk);
      rst = 1'b1;
      n_ov = 0;
      repeat (30) begin
         @(negedge clk);
         if (a_ov) n_ov++;
      end
      chk("post_rst_no_valid", n_ov, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1);
   end
endmodule

// File: doc/echo_seq_ctrl.md
Name: echo_seq_ctrl

Overview:
- Hardware sequencer for the echo-cancellation chain.
- Once per sample period it fires one-shot enable pulses to the processing stages in order and waits for each stage's ready. Stages are sig16b_to_double, lag_generator, para_approx, echo_cancelation.
- Stage set, timing and mode are parametrised. Per-stage timeout and sample-overrun detection are built in.
- Sits beside the datapath and drives its enable lines. Signals the output converter when a sample result is valid.

Parameters:
- SAMPLE_CYCLE, 4000: clocks per sample period.
- CNT_W, 13: width of the sample-period counter; must satisfy 2^CNT_W >= SAMPLE_CYCLE.
- N_STAGES, 4: number of sequenced stages.
- PULSE_W, 4: enable pulse length in clocks; minimum 1.
- TIMEOUT, 2048: maximum clocks from a stage's enable rise to its ready rise.
- ADAPT_MASK, 4'b0111: stages run when mode=1 (convert, lag, para_approx).
- CANCEL_MASK, 4'b1011: stages run when mode=0 (convert, lag, echo_cancel).

Ports:
- clk_operation  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- run_en  in  1  allows sample ticks to start sequences.
- mode  in  1  1 = adapt, 0 = cancel; latched at each tick.
- stage_ready  in  N_STAGES  level ready from each stage.
- stage_enable  out  N_STAGES  one-hot enable pulses.
- sampling_cycle_counter  out  CNT_W  sample-period counter.
- sample_tick  out  1  high for the cycle in which the counter is 0.
- out_valid  out  1  one-cycle pulse when a sequence completes.
- out_sel  out  1  mode latched for the completed sequence (1 = e, 0 = signal_without_echo).
- busy  out  1  FSM is not IDLE.
- timeout_err  out  N_STAGES  sticky per-stage timeout flags.
- overrun  out  1  sticky; a tick arrived while busy.
- clr_err  in  1  synchronous clear of timeout_err and overrun.

Behaviour:
- Reset (rst=0), effective immediately:
  - counter = 0; FSM = IDLE; stage index = 0.
  - All outputs are 0, except sample_tick, which follows counter==0.
- Counter:
  - Counts 0..SAMPLE_CYCLE-1 and wraps to 0. It runs regardless of run_en.
  - sample_tick is combinational: counter==0.
- FSM states: IDLE, SELECT, FIRE, WAIT, DONE.
  - IDLE: if sample_tick && run_en, latch mode into mode_q, select mask = mode ? ADAPT_MASK : CANCEL_MASK, set idx = 0, go to SELECT.
  - SELECT (1 cycle per stage examined):
    - If mask[idx]=1: go to FIRE.
    - Else if idx==N_STAGES-1: go to DONE.
    - Else idx++ and stay in SELECT.
  - FIRE: drive stage_enable[idx]=1 for exactly PULSE_W cycles, then go to WAIT. The timeout counter starts at the first FIRE cycle.
  - WAIT:
    - Proceed on the latched ready edge. If idx==N_STAGES-1 go to DONE; else idx++ and go to SELECT.
    - If the timeout count reaches TIMEOUT with no edge: set timeout_err[idx], go to IDLE. out_valid is not raised.
  - DONE: out_valid=1 and out_sel=mode_q for one cycle, then go to IDLE.
- Ready qualification:
  - A rising edge of stage_ready[idx] (registered previous value vs. current) is captured from the first FIRE cycle onward. A level that is already high at FIRE entry does not count.
  - An edge captured during FIRE is held and consumed in the first WAIT cycle.
- Ticks while busy:
  - If sample_tick && run_en while not IDLE: set overrun, drop the tick, and let the current sequence continue.
- Simultaneous events:
  - clr_err and a new error in the same cycle: the error wins (flag is set).
  - run_en deasserted mid-sequence: the sequence completes normally; no new ticks start.
- Reset mid-sequence: enable outputs drop immediately; no out_valid is issued.
- Latency: each executed stage costs 1 + PULSE_W + (WAIT cycles); each skipped stage costs 1.

Optional Feature:
- Macro: ECHO_SEQ_STATS_EN.
- Defined:
  - Adds output last_latency[15:0]: clocks from tick to the DONE cycle, updated at DONE.
  - Adds output max_latency[15:0]: running maximum; cleared by clr_err and by reset; saturates at 16'hFFFF.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package echo_seq_pkg: FSM state encoding, stage index constants (ST_CONV=0, ST_LAG=1, ST_ADAPT=2, ST_CANCEL=3), default mask constants.
- Sub-module sample_timer: the period counter and sample_tick generation, parameters SAMPLE_CYCLE and CNT_W.

Test Plan:
- Adapt run. Setup: SAMPLE_CYCLE=64, PULSE_W=4, mode=1; stub stages raise ready 3 clocks after enable rise. Tick at T -> enables on stage 0 at T+2..T+5, stage 1 at T+8..T+11, stage 2 at T+14..T+17; stage 3 never enabled; out_valid with out_sel=1 at T+20.
- Cancel run. Same setup, mode=0 -> stage 2 never enabled; stage 3 enabled at T+15..T+18; out_valid with out_sel=0 at T+20.
- Timeout. Stub stage 1 never raises ready; TIMEOUT=16 -> timeout_err=4'b0010 after 16 clocks; no out_valid; FSM returns to IDLE and the next tick runs normally.
- Stale ready. stage_ready[0] held high before the tick -> no advance until a fresh 0->1 edge.
- Overrun. SAMPLE_CYCLE=16 with a 3-stage sequence of about 20 clocks -> overrun=1; the tick is dropped; clr_err returns overrun to 0.
- Reset. Assert rst low during FIRE -> stage_enable=0 the same cycle; counter=0; out_valid stays 0.
